load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_TOP, 10000, highest byte index of data memory; accesses with req_addr >= MEM_TOP fault.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port req_valid, input, 1, pipeline presents a memory request.
REQ-005 SHALL have port req_ready, output, 1, unit accepts a request this cycle.
REQ-006 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_byte, input, 1, 1 = byte access, 0 = 16-bit word access.
REQ-008 SHALL have port req_signed, input, 1, byte load sign-extends when 1 and zero-extends when 0; ignored otherwise.
REQ-009 SHALL have port req_addr, input, 16, byte address.
REQ-010 SHALL have port req_wdata, input, 16, store data; byte stores use [7:0].
REQ-011 SHALL have port resp_valid, output, 1, response available.
REQ-012 SHALL have port resp_ready, input, 1, pipeline consumes the response.
REQ-013 SHALL have port resp_rdata, output, 16, load result; 0 for stores and faults.
REQ-014 SHALL have port resp_fault, output, 1, request was out of range and was not performed.
REQ-015 SHALL have port mem_addr, output, 16, data memory byte address.
REQ-016 SHALL have port mem_ren, output, 1, data memory read enable.
REQ-017 SHALL have port mem_wen, output, 1, data memory write enable, one-cycle pulse.
REQ-018 SHALL have port mem_wdata, output, 16, memory write data.
REQ-019 SHALL have port mem_rdata, input, 16, combinational memory read data, returned the same cycle.

Function
REQ-020 Memory port convention SHALL be:
- Read returns {byte[a], byte[a+1]}.
- Write places mem_wdata[7:0] at byte[a] and [15:8] at byte[a+1].
REQ-021 Architectural view SHALL be big-endian: a word store drives mem_wdata = {D[7:0], D[15:8]}, so a later word load returns D.
REQ-022 FSM states SHALL be IDLE, RD, WR, RESP.
REQ-023 IDLE SHALL hold req_ready=1; the request is latched (addr, wdata, flags) on req_valid.
REQ-024 IDLE transitions SHALL be:
- fault -> RESP
- load -> RD
- word store -> WR
- byte store -> RD
REQ-025 RD SHALL drive mem_ren=1 and mem_addr=latched addr, and SHALL capture mem_rdata at the clock edge.
REQ-026 RD SHALL go to RESP for a load and to WR for a byte store.
REQ-027 WR SHALL drive mem_wen=1 for exactly one cycle, then go to RESP.
REQ-028 Byte-store merge SHALL be: new word = {D[7:0], captured[7:0]}, written swapped per REQ-021; byte[a+1] is preserved.
REQ-029 Byte load result SHALL be captured[15:8], sign- or zero-extended per req_signed; word load result SHALL be the captured word.
REQ-030 RESP SHALL hold resp_valid=1 and stable resp_* until resp_ready, then return to IDLE; no new request is accepted before that.
REQ-031 Latency from accept edge to resp_valid SHALL be:
- fault: 1 cycle
- load or word store: 2 cycles
- byte store: 3 cycles
REQ-032 Faulting requests SHALL never assert mem_ren or mem_wen.
REQ-033 mem_ren and mem_wen SHALL never be asserted together; both SHALL be 0 in IDLE and RESP.
REQ-034 mem_addr and mem_wdata SHALL be stable for the whole RD/WR cycle.

Reset
REQ-035 While rst=1 the FSM SHALL be in IDLE and all latched registers SHALL be 0.
REQ-036 Reset values SHALL be: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_ren=0, mem_wen=0, mem_addr=0, mem_wdata=0.
REQ-037 Reset mid-operation SHALL abandon the request with no write issued and no response returned; mem_wen SHALL drop immediately (asynchronously).

Structure
REQ-038 Package cpu_mem_pkg SHALL hold MEM_TOP, the FSM state type and the byte-swap/extend helper functions.
REQ-039 Sub-module lsu_byte_merge SHALL hold the combinational byte merge, extend and swap logic; the FSM stays in load_store_unit.

Verification (memory bytes 0..9 after memory init = 2b cd 00 00 12 34 de ad be ef)
REQ-040 Word load at addr 0 -> resp_rdata=0x2BCD, resp_fault=0, 2 cycles after accept.
REQ-041 Byte load at addr 6:
- signed -> 0xFFDE
- unsigned -> 0x00DE
REQ-042 Word store 0x1234 at addr 20 -> one mem_wen pulse with mem_wdata=0x3412; a following word load at addr 20 returns 0x1234.
REQ-043 Byte store 0x99 at addr 8 -> RD then WR with mem_wdata=0xEF99; a following word load at addr 8 returns 0x99EF; resp 3 cycles after accept.
REQ-044 Any access at addr 10000 -> resp_fault=1, resp_rdata=0, no mem_ren/mem_wen; a stalled resp_ready=0 for 5 cycles holds the response stable.
REQ-045 rst asserted during RD of a byte store at addr 4 -> no mem_wen pulse; a later word load at addr 4 returns 0x1234.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the load/store unit: address limit, FSM state type
// and the byte-swap / extend helpers used between the big-endian view and the memory port.
package cpu_mem_pkg;

   localparam int unsigned MEM_TOP = 10000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } lsu_state_t;

   // Exchange the two bytes of a 16-bit word.
   function automatic logic [15:0] swap_bytes(input logic [15:0] w);
      return {w[7:0], w[15:8]};
   endfunction

   // Widen a byte to 16 bits, sign- or zero-extending.
   function automatic logic [15:0] extend_byte(input logic [7:0] b, input logic sgn);
      return sgn ? {{8{b[7]}}, b} : {8'h00, b};
   endfunction

endpackage

// File: rtl/lsu_byte_merge.sv
// Combinational data path of the load/store unit: load result selection and
// extension, and the read-modify-write merge for byte stores.
module lsu_byte_merge
   import cpu_mem_pkg::*;
(
   input  logic [15:0] rdata,
   input  logic [15:0] wdata,
   input  logic        is_byte,
   input  logic        is_signed,
   output logic [15:0] load_data,
   output logic [15:0] store_data
);

   logic [15:0] merged_s;

   // Byte loads take byte[a] (upper half of the read word); byte stores replace
   // byte[a] and keep byte[a+1], then swap into memory-port order.
   always_comb begin
      merged_s   = {wdata[7:0], rdata[7:0]};
      load_data  = 16'h0000;
      store_data = 16'h0000;
      if (is_byte) begin
         load_data  = extend_byte(rdata[15:8], is_signed);
         store_data = swap_bytes(merged_s);
      end else begin
         load_data  = rdata;
         store_data = swap_bytes(wdata);
      end
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, performs word or byte
// accesses on a combinational-read memory port (byte stores as read-modify-write),
// and returns a held response with a fault flag for out-of-range addresses.
module load_store_unit #(
   parameter int unsigned MEM_TOP = cpu_mem_pkg::MEM_TOP
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_byte,
   input  logic        req_signed,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [15:0] resp_rdata,
   output logic        resp_fault,
   output logic [15:0] mem_addr,
   output logic        mem_ren,
   output logic        mem_wen,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata
);
   import cpu_mem_pkg::*;

   localparam logic [15:0] ADDR_LIMIT = MEM_TOP[15:0];

   lsu_state_t  state_r;
   logic [15:0] addr_r;
   logic [15:0] wdata_r;
   logic        write_r;
   logic        byte_r;
   logic        signed_r;
   logic [15:0] load_data_s;
   logic [15:0] store_data_s;

   lsu_byte_merge u_merge (
      .rdata      (mem_rdata),
      .wdata      (wdata_r),
      .is_byte    (byte_r),
      .is_signed  (signed_r),
      .load_data  (load_data_s),
      .store_data (store_data_s)
   );

   // Request FSM with all outputs registered; reset clears everything at once,
   // so an in-flight request is abandoned and mem_wen falls immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= IDLE;
         addr_r     <= 16'h0000;
         wdata_r    <= 16'h0000;
         write_r    <= 1'b0;
         byte_r     <= 1'b0;
         signed_r   <= 1'b0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= 16'h0000;
         resp_fault <= 1'b0;
         mem_addr   <= 16'h0000;
         mem_ren    <= 1'b0;
         mem_wen    <= 1'b0;
         mem_wdata  <= 16'h0000;
      end else begin
         case (state_r)
            IDLE: begin
               mem_ren <= 1'b0;
               mem_wen <= 1'b0;
               if (req_valid) begin
                  addr_r    <= req_addr;
                  wdata_r   <= req_wdata;
                  write_r   <= req_write;
                  byte_r    <= req_byte;
                  signed_r  <= req_signed;
                  req_ready <= 1'b0;
                  if (req_addr >= ADDR_LIMIT) begin
                     state_r    <= RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                     resp_rdata <= 16'h0000;
                  end else begin
                     mem_addr <= req_addr;
                     if (req_write && !req_byte) begin
                        state_r   <= WR;
                        mem_wen   <= 1'b1;
                        mem_wdata <= swap_bytes(req_wdata);
                     end else begin
                        // loads and byte stores both read first
                        state_r <= RD;
                        mem_ren <= 1'b1;
                     end
                  end
               end else begin
                  req_ready <= 1'b1;
               end
            end
            RD: begin
               mem_ren <= 1'b0;
               if (write_r) begin
                  state_r   <= WR;
                  mem_wen   <= 1'b1;
                  mem_wdata <= store_data_s;
               end else begin
                  state_r    <= RESP;
                  resp_valid <= 1'b1;
                  resp_fault <= 1'b0;
                  resp_rdata <= load_data_s;
               end
            end
            WR: begin
               mem_wen    <= 1'b0;
               state_r    <= RESP;
               resp_valid <= 1'b1;
               resp_fault <= 1'b0;
               resp_rdata <= 16'h0000;
            end
            RESP: begin
               if (resp_ready) begin
                  state_r    <= IDLE;
                  resp_valid <= 1'b0;
                  resp_fault <= 1'b0;
                  resp_rdata <= 16'h0000;
                  req_ready  <= 1'b1;
               end else begin
                  state_r <= RESP;
               end
            end
            default: begin
               state_r    <= IDLE;
               req_ready  <= 1'b1;
               resp_valid <= 1'b0;
               mem_ren    <= 1'b0;
               mem_wen    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected
// responses, a monitor pops and compares them; a byte-array memory model
// sits on the memory port.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write, req_byte, req_signed;
   logic [15:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_fault;
   logic [15:0] resp_rdata;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ren, mem_wen;

   load_store_unit #(.MEM_TOP(10000)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_fault(resp_fault), .mem_addr(mem_addr),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int ren_cnt = 0;
   int wen_cnt = 0;
   logic [15:0] last_wdata = 16'h0000;
   bit mon_busy = 1'b0;

   typedef struct {
      logic [15:0] rdata;
      logic        fault;
      int          acc;
      int          lat;
      int          stall;
      string       name;
   } exp_t;
   exp_t q[$];

   logic [7:0] mem [0:10001];

   always @(posedge clk) cyc <= cyc + 1;

   // memory model: init contents, then byte writes on mem_wen
   initial begin
      for (int i = 0; i < 10002; i++) mem[i] = 8'h00;
      mem[0] = 8'h2b; mem[1] = 8'hcd; mem[2] = 8'h00; mem[3] = 8'h00;
      mem[4] = 8'h12; mem[5] = 8'h34; mem[6] = 8'hde; mem[7] = 8'had;
      mem[8] = 8'hbe; mem[9] = 8'hef;
      forever begin
         @(posedge clk);
         if (mem_wen && mem_addr < 16'd10001) begin
            mem[mem_addr]     <= mem_wdata[7:0];
            mem[mem_addr + 1] <= mem_wdata[15:8];
         end
      end
   end

   always_comb begin
      mem_rdata = 16'h0000;
      if (mem_addr < 16'd10001) mem_rdata = {mem[mem_addr], mem[mem_addr + 1]};
   end

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chki(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // memory port activity counters and ren/wen exclusion
   initial begin
      forever begin
         @(negedge clk);
         if (mem_ren) ren_cnt++;
         if (mem_wen) begin
            wen_cnt++;
            last_wdata = mem_wdata;
         end
         if (mem_ren && mem_wen) begin
            checks++;
            errors++;
            $display("FAIL ren_wen_overlap: got both high expected exclusive");
         end
      end
   end

   // response monitor: pops expectations, checks values, latency and stall stability
   initial begin
      exp_t cur;
      int hold = 0;
      resp_ready = 1'b0;
      forever begin
         @(negedge clk);
         resp_ready = 1'b0;
         if (rst) begin
            mon_busy = 1'b0;
         end else if (resp_valid) begin
            if (!mon_busy) begin
               if (q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_resp: got resp_valid=1 expected no response");
                  resp_ready = 1'b1;
               end else begin
                  cur = q.pop_front();
                  mon_busy = 1'b1;
                  hold = cur.stall;
                  chk({cur.name, "_rdata"}, resp_rdata, cur.rdata);
                  chk({cur.name, "_fault"}, {15'd0, resp_fault}, {15'd0, cur.fault});
                  chki({cur.name, "_latency"}, cyc - cur.acc, cur.lat);
               end
            end else begin
               chk({cur.name, "_held_rdata"}, resp_rdata, cur.rdata);
               chk({cur.name, "_held_fault"}, {15'd0, resp_fault}, {15'd0, cur.fault});
            end
            if (mon_busy) begin
               if (hold == 0) begin
                  resp_ready = 1'b1;
                  mon_busy = 1'b0;
               end else begin
                  hold--;
               end
            end
         end
      end
   end

   task automatic issue(string nm, bit w, bit b, bit s, logic [15:0] a, logic [15:0] d,
                        logic [15:0] er, bit ef, int lat, int stall,
                        int exp_ren, int exp_wen, logic [15:0] exp_wdata);
      int t;
      int ren0, wen0;
      exp_t e;
      t = 0;
      @(negedge clk);
      while (!req_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL %s_accept_timeout: got req_ready=0 expected 1", nm);
         return;
      end
      ren0 = ren_cnt;
      wen0 = wen_cnt;
      req_valid = 1'b1; req_write = w; req_byte = b; req_signed = s;
      req_addr = a; req_wdata = d;
      e.rdata = er; e.fault = ef; e.acc = cyc; e.lat = lat; e.stall = stall; e.name = nm;
      q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
      req_addr = 16'h0000; req_wdata = 16'h0000;
      t = 0;
      while ((q.size() != 0 || mon_busy) && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (q.size() != 0 || mon_busy) begin
         checks++;
         errors++;
         $display("FAIL %s_resp_timeout: got no response expected one", nm);
         q.delete();
      end
      @(negedge clk);
      chki({nm, "_ren_pulses"}, ren_cnt - ren0, exp_ren);
      chki({nm, "_wen_pulses"}, wen_cnt - wen0, exp_wen);
      if (exp_wen > 0) chk({nm, "_mem_wdata"}, last_wdata, exp_wdata);
   endtask

   initial begin
      int wen0;
      rst = 1'b1;
      req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
      req_addr = 16'h0000; req_wdata = 16'h0000;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", {15'd0, req_ready}, 16'h0001);
      chk("rst_resp_valid", {15'd0, resp_valid}, 16'h0000);
      chk("rst_resp_rdata", resp_rdata, 16'h0000);
      chk("rst_resp_fault", {15'd0, resp_fault}, 16'h0000);
      chk("rst_mem_ren", {15'd0, mem_ren}, 16'h0000);
      chk("rst_mem_wen", {15'd0, mem_wen}, 16'h0000);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_mem_wdata", mem_wdata, 16'h0000);
      rst = 1'b0;

      //     name          w  b  s  addr      wdata     rdata     f  lat stall ren wen wdata
      issue("wload0",     0, 0, 0, 16'd0,    16'h0000, 16'h2BCD, 0, 2, 0,    1,  0, 16'h0000);
      issue("bload6s",    0, 1, 1, 16'd6,    16'h0000, 16'hFFDE, 0, 2, 0,    1,  0, 16'h0000);
      issue("bload6u",    0, 1, 0, 16'd6,    16'h0000, 16'h00DE, 0, 2, 0,    1,  0, 16'h0000);
      issue("bload4s",    0, 1, 1, 16'd4,    16'h0000, 16'h0012, 0, 2, 0,    1,  0, 16'h0000);
      issue("wstore20",   1, 0, 0, 16'd20,   16'h1234, 16'h0000, 0, 2, 0,    0,  1, 16'h3412);
      issue("wload20",    0, 0, 0, 16'd20,   16'h0000, 16'h1234, 0, 2, 0,    1,  0, 16'h0000);
      issue("bstore8",    1, 1, 0, 16'd8,    16'hAA99, 16'h0000, 0, 3, 0,    1,  1, 16'hEF99);
      issue("wload8",     0, 0, 0, 16'd8,    16'h0000, 16'h99EF, 0, 2, 0,    1,  0, 16'h0000);
      issue("bload9u",    0, 1, 0, 16'd9,    16'h0000, 16'h00EF, 0, 2, 0,    1,  0, 16'h0000);
      issue("fault_ld",   0, 0, 0, 16'd10000,16'h0000, 16'h0000, 1, 1, 5,    0,  0, 16'h0000);
      issue("fault_st",   1, 1, 0, 16'd10000,16'h5555, 16'h0000, 1, 1, 0,    0,  0, 16'h0000);
      issue("wload9999",  0, 0, 0, 16'd9999, 16'h0000, 16'h0000, 0, 2, 0,    1,  0, 16'h0000);

      // reset during the read phase of a byte store at addr 4
      @(negedge clk);
      wen0 = wen_cnt;
      req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0;
      req_addr = 16'd4; req_wdata = 16'h0077;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
      chk("midrst_in_rd", {15'd0, mem_ren}, 16'h0001);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_ren_drop", {15'd0, mem_ren}, 16'h0000);
      chk("midrst_wen_low", {15'd0, mem_wen}, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chki("midrst_wen_pulses", wen_cnt - wen0, 0);
      chk("midrst_req_ready", {15'd0, req_ready}, 16'h0001);
      issue("wload4",     0, 0, 0, 16'd4,    16'h0000, 16'h1234, 0, 2, 0,    1,  0, 16'h0000);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
